// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encoding, datapath widths
// and the word-alignment mask.
package pipe_pkg;

    localparam int PIPE_ADDR_W = 32;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_W  = 5;

    localparam logic [1:0] WORD_OFS_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic misaligned(input logic [1:0] lo);
        return (lo & WORD_OFS_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the write controls and
// leaves the data fields untouched.
module mem_wb_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_W  = PIPE_REG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bubble,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_W-1:0]  write_reg,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [DATA_W-1:0] ReadData_wb,
    output logic [DATA_W-1:0] ALUresult_wb,
    output logic [REG_W-1:0]  WriteReg_wb
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWrite_wb  <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            ReadData_wb  <= '0;
            ALUresult_wb <= '0;
            WriteReg_wb  <= '0;
        end else if (bubble) begin
            RegWrite_wb <= 1'b0;
            MemtoReg_wb <= 1'b0;
        end else begin
            RegWrite_wb  <= reg_write;
            MemtoReg_wb  <= mem_to_reg;
            ReadData_wb  <= read_data;
            ALUresult_wb <= alu_result;
            WriteReg_wb  <= write_reg;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory bus FSM, front-end stall and MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses via misalign_wb.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = PIPE_ADDR_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_W  = PIPE_REG_W
) (
    input  logic              clock,
    input  logic              reset,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_wb,
`endif
    input  logic              MemRead_mem,
    input  logic              MemWrite_mem,
    input  logic              MemtoReg_mem,
    input  logic              RegWrite_mem,
    input  logic [DATA_W-1:0] ALUresult_mem,
    input  logic [DATA_W-1:0] ReadData2_mem,
    input  logic [REG_W-1:0]  WriteReg_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_mem,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [DATA_W-1:0] ReadData_wb,
    output logic [DATA_W-1:0] ALUresult_wb,
    output logic [REG_W-1:0]  WriteReg_wb
);

    mem_state_t        state_q, state_d;
    logic              memop, ready_hit, start_req, trap_hit;
    logic              wb_regwrite, wb_memtoreg;
    logic [DATA_W-1:0] held_q, wb_rdata;

    assign memop     = MemRead_mem | MemWrite_mem;
    assign ready_hit = (state_q == WAIT) & dmem_ready;

`ifdef MEM_MISALIGN_TRAP_EN
    logic trap_q;

    assign trap_hit = (state_q == IDLE) & memop
                    & misaligned(ALUresult_mem[1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trap_q      <= 1'b0;
            misalign_wb <= 1'b0;
        end else begin
            trap_q      <= trap_hit;
            misalign_wb <= trap_q & (state_q == DONE);
        end
    end

    assign wb_regwrite = RegWrite_mem & ~trap_q;
    assign wb_memtoreg = MemtoReg_mem & ~trap_q;
`else
    assign trap_hit    = 1'b0;
    assign wb_regwrite = RegWrite_mem;
    assign wb_memtoreg = MemtoReg_mem;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (memop) state_d = trap_hit ? DONE : WAIT;
            WAIT: if (dmem_ready) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_mem = 1'b0;
        start_req = 1'b0;
        wb_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                stall_mem = memop;
                start_req = memop & ~trap_hit;
            end
            WAIT: stall_mem = 1'b1;
            DONE: wb_rdata = held_q;
            default: ;
        endcase
    end

    // Bus signals stay frozen for the whole WAIT phase; only req drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (start_req) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_mem;
            dmem_addr  <= {ALUresult_mem[ADDR_W-1:2], 2'b00};
            dmem_wdata <= ReadData2_mem;
        end else if (ready_hit) begin
            dmem_req <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          held_q <= '0;
        else if (ready_hit) held_q <= dmem_we ? '0 : dmem_rdata;
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clock        (clock),
        .reset        (reset),
        .bubble       (stall_mem),
        .reg_write    (wb_regwrite),
        .mem_to_reg   (wb_memtoreg),
        .read_data    (wb_rdata),
        .alu_result   (ALUresult_mem),
        .write_reg    (WriteReg_mem),
        .RegWrite_wb  (RegWrite_wb),
        .MemtoReg_wb  (MemtoReg_wb),
        .ReadData_wb  (ReadData_wb),
        .ALUresult_wb (ALUresult_wb),
        .WriteReg_wb  (WriteReg_wb)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// reset mid-access, address alignment and back-to-back accesses.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead_mem = 1'b0;
    logic        MemWrite_mem = 1'b0;
    logic        MemtoReg_mem = 1'b0;
    logic        RegWrite_mem = 1'b0;
    logic [31:0] ALUresult_mem = '0;
    logic [31:0] ReadData2_mem = '0;
    logic [4:0]  WriteReg_mem = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_mem;
    logic        RegWrite_wb, MemtoReg_wb;
    logic [31:0] ReadData_wb, ALUresult_wb;
    logic [4:0]  WriteReg_wb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_wb;
`endif

    int tests = 0;
    int failed = 0;

    mem_access_stage dut (
        .clock         (clock),
        .reset         (reset),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_wb   (misalign_wb),
`endif
        .MemRead_mem   (MemRead_mem),
        .MemWrite_mem  (MemWrite_mem),
        .MemtoReg_mem  (MemtoReg_mem),
        .RegWrite_mem  (RegWrite_mem),
        .ALUresult_mem (ALUresult_mem),
        .ReadData2_mem (ReadData2_mem),
        .WriteReg_mem  (WriteReg_mem),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .stall_mem     (stall_mem),
        .RegWrite_wb   (RegWrite_wb),
        .MemtoReg_wb   (MemtoReg_wb),
        .ReadData_wb   (ReadData_wb),
        .ALUresult_wb  (ALUresult_wb),
        .WriteReg_wb   (WriteReg_wb)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] wreg);
        MemRead_mem   = rd;
        MemWrite_mem  = wr;
        MemtoReg_mem  = m2r;
        RegWrite_mem  = rw;
        ALUresult_mem = alu;
        ReadData2_mem = wd;
        WriteReg_mem  = wreg;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_stall", stall_mem, 0);
        chk("rst_rw", RegWrite_wb, 0);
        chk("rst_rd", ReadData_wb, 0);
        reset = 1'b0;

        // ALU op passes straight through
        drive(0, 0, 0, 1, 32'hAA, 32'h0, 5'd5);
        chk("alu_stall", stall_mem, 0);
        tick();
        chk("alu_rw", RegWrite_wb, 1);
        chk("alu_res", ALUresult_wb, 32'hAA);
        chk("alu_wreg", WriteReg_wb, 5);
        chk("alu_m2r", MemtoReg_wb, 0);
        chk("alu_req", dmem_req, 0);
        nop();
        tick();
        chk("alu_rw_off", RegWrite_wb, 0);

        // load 0x100, ready in the second WAIT cycle
        drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd7);
        chk("ld_stall0", stall_mem, 1);
        tick();
        chk("ld_req", dmem_req, 1);
        chk("ld_we", dmem_we, 0);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_stall1", stall_mem, 1);
        chk("ld_bubble", RegWrite_wb, 0);
        tick();
        chk("ld_stall2", stall_mem, 1);
        chk("ld_req_hold", dmem_req, 1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h00000055;
        #1;
        chk("ld_done_stall", stall_mem, 0);
        chk("ld_req_drop", dmem_req, 0);
        chk("ld_done_rw", RegWrite_wb, 0);
        tick();
        dmem_ready = 1'b0;
        chk("ld_rw", RegWrite_wb, 1);
        chk("ld_m2r", MemtoReg_wb, 1);
        chk("ld_data", ReadData_wb, 32'hDEADBEEF);
        chk("ld_wreg", WriteReg_wb, 7);
        nop();
        chk("ld_after_stall", stall_mem, 0);
        tick();
        chk("ld_rw_once", RegWrite_wb, 0);
        chk("ld_stray_req", dmem_req, 0);

        // store 0x204, ready in the first WAIT cycle
        drive(0, 1, 0, 0, 32'h204, 32'h12345678, 5'd0);
        chk("st_stall0", stall_mem, 1);
        tick();
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h204);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_ready = 1'b0;
        chk("st_req_drop", dmem_req, 0);
        chk("st_done_stall", stall_mem, 0);
        chk("st_rw_mid", RegWrite_wb, 0);
        tick();
        chk("st_rw", RegWrite_wb, 0);
        chk("st_rdata", ReadData_wb, 0);
        chk("st_alu", ALUresult_wb, 32'h204);
        nop();
        tick();

        // misaligned load 0x103
        drive(1, 0, 1, 1, 32'h103, 32'h0, 5'd9);
        tick();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_noreq", dmem_req, 0);
        chk("mis_stall", stall_mem, 0);
        tick();
        chk("mis_flag", misalign_wb, 1);
        chk("mis_rw", RegWrite_wb, 0);
        nop();
        tick();
        chk("mis_flag_off", misalign_wb, 0);
        chk("mis_req_off", dmem_req, 0);
`else
        chk("mis_req", dmem_req, 1);
        chk("mis_addr", dmem_addr, 32'h100);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ready = 1'b0;
        tick();
        chk("mis_data", ReadData_wb, 32'hCAFEF00D);
        chk("mis_rw", RegWrite_wb, 1);
        nop();
        tick();
`endif

        // reset in the middle of a WAIT
        drive(0, 0, 0, 1, 32'h77, 32'h0, 5'd3);
        tick();
        drive(1, 0, 1, 1, 32'h40, 32'h0, 5'd4);
        tick();
        chk("rw_pre_req", dmem_req, 1);
        chk("rw_pre_alu", ALUresult_wb, 32'h77);
        nop();
        reset = 1'b1;
        #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_addr", dmem_addr, 0);
        chk("rw_alu", ALUresult_wb, 0);
        chk("rw_wreg", WriteReg_wb, 0);
        chk("rw_stall", stall_mem, 0);
        tick();
        reset = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h99;
        tick();
        dmem_ready = 1'b0;
        chk("rw_stray_rd", ReadData_wb, 0);
        chk("rw_stray_rw", RegWrite_wb, 0);
        chk("rw_stray_req", dmem_req, 0);

        // back-to-back loads 0x10 and 0x14
        drive(1, 0, 1, 1, 32'h10, 32'h0, 5'd1);
        tick();
        chk("bb1_addr", dmem_addr, 32'h10);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111;
        tick();
        dmem_ready = 1'b0;
        tick();
        chk("bb1_rw", RegWrite_wb, 1);
        chk("bb1_data", ReadData_wb, 32'h1111);
        chk("bb1_wreg", WriteReg_wb, 1);
        drive(1, 0, 1, 1, 32'h14, 32'h0, 5'd2);
        chk("bb_idle_req", dmem_req, 0);
        chk("bb_idle_stall", stall_mem, 1);
        tick();
        chk("bb2_req", dmem_req, 1);
        chk("bb2_addr", dmem_addr, 32'h14);
        chk("bb2_nodup", RegWrite_wb, 0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h2222;
        tick();
        dmem_ready = 1'b0;
        chk("bb2_done_rw", RegWrite_wb, 0);
        tick();
        chk("bb2_rw", RegWrite_wb, 1);
        chk("bb2_data", ReadData_wb, 32'h2222);
        chk("bb2_wreg", WriteReg_wb, 2);
        nop();
        tick();
        chk("bb2_once", RegWrite_wb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
